// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG TCK shifter: controller state encoding,
// bit positions of TMS/TDI inside the player's vector_data word, the half
// period substituted for a programmed value of zero, and a small helper that
// drops one captured TDO bit into the byte being packed.
// -----------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        LOW,
        HIGH,
        FLUSH
    } state_t;

    localparam int unsigned VEC_TMS_BIT         = 0;
    localparam int unsigned VEC_TDI_BIT         = 1;
    localparam int unsigned DEFAULT_HALF_PERIOD = 1;

    // Returns sr with bit 'pos' replaced by 'b'.
    function automatic logic [7:0] insert_bit(input logic [7:0] sr,
                                              input logic [2:0] pos,
                                              input logic       b);
        logic [7:0] r;
        r      = sr;
        r[pos] = b;
        return r;
    endfunction

endpackage

// File: rtl/jtag_tck_shifter_if.sv
// -----------------------------------------------------------------------------
// jtag_tck_shifter_if
// Bus bundle between the shifter and its neighbours:
//   get_next_data / data_ready / vector_data : level handshake with the player
//   cap_addr / cap_wr_data / cap_we          : capture RAM write port
// master : the shifter side (drives requests and capture writes)
// slave  : the player / capture RAM side
// -----------------------------------------------------------------------------
interface jtag_tck_shifter_if #(
    parameter int unsigned CAP_ADDR_WIDTH = 12
);

    logic                      get_next_data;
    logic                      data_ready;
    logic [1:0]                vector_data;
    logic [CAP_ADDR_WIDTH-1:0] cap_addr;
    logic [7:0]                cap_wr_data;
    logic                      cap_we;

    modport master (
        output get_next_data,
        input  data_ready,
        input  vector_data,
        output cap_addr,
        output cap_wr_data,
        output cap_we
    );

    modport slave (
        input  get_next_data,
        output data_ready,
        output vector_data,
        input  cap_addr,
        input  cap_wr_data,
        input  cap_we
    );

endinterface

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (output resets to 0)
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/jtag_tck_shifter.sv
// -----------------------------------------------------------------------------
// jtag_tck_shifter
// Pulls one (TMS,TDI) pair per JTAG bit from the vector player, drives the
// TCK/TMS/TDI pins with a programmable half period, samples TDO on each bit and
// packs the samples LSB-first into bytes written to a capture RAM.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   start, abort    : one-cycle command pulses
//   bit_count       : bits per run (latched at start)
//   tck_half_period : clk cycles per TCK half period (latched, 0 acts as 1)
//   bus             : player handshake + capture RAM port (master side)
//   tck, tms, tdi   : JTAG outputs
//   tdo             : JTAG input (asynchronous)
//   busy, done      : run in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module jtag_tck_shifter
    import jtag_pkg::*;
#(
    parameter int unsigned DIV_WIDTH      = 16,
    parameter int unsigned CAP_ADDR_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          bit_count,
    input  logic [DIV_WIDTH-1:0] tck_half_period,
    jtag_tck_shifter_if.master   bus,
    output logic                 tck,
    output logic                 tms,
    output logic                 tdi,
    input  logic                 tdo,
    output logic                 busy,
    output logic                 done
);

    state_t                    state_q, state_d;
    logic [31:0]               bit_count_q, bit_count_d;
    logic [31:0]               bit_idx_q, bit_idx_d;
    logic [DIV_WIDTH-1:0]      half_q, half_d;
    logic [DIV_WIDTH-1:0]      div_cnt_q, div_cnt_d;
    logic [7:0]                cap_sr_q, cap_sr_d;
    logic [7:0]                cap_wr_data_q, cap_wr_data_d;
    logic [CAP_ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic                      cap_we_q, cap_we_d;
    logic                      tck_q, tck_d;
    logic                      tms_q, tms_d;
    logic                      tdi_q, tdi_d;
    logic                      gnd_q, gnd_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      dr_s;
    logic                      tdo_s;
    logic                      half_last;
    logic                      last_bit;
    logic [7:0]                cap_byte;
    logic [DIV_WIDTH-1:0]      half_eff;

    sync2 u_dr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.data_ready),
        .q     (dr_s)
    );

    sync2 u_tdo_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tdo),
        .q     (tdo_s)
    );

    assign half_eff  = (tck_half_period == '0) ? DIV_WIDTH'(DEFAULT_HALF_PERIOD)
                                               : tck_half_period;
    assign half_last = (div_cnt_q == half_q - DIV_WIDTH'(1));
    assign last_bit  = ((bit_idx_q + 32'd1) == bit_count_q);
    assign cap_byte  = insert_bit(cap_sr_q, bit_idx_q[2:0], tdo_s);

    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        bit_idx_d     = bit_idx_q;
        half_d        = half_q;
        div_cnt_d     = div_cnt_q;
        cap_sr_d      = cap_sr_q;
        cap_wr_data_d = cap_wr_data_q;
        cap_we_d      = 1'b0;
        tck_d         = tck_q;
        tms_d         = tms_q;
        tdi_d         = tdi_q;
        gnd_d         = gnd_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        // The address advances the cycle after each write strobe.
        cap_addr_d    = cap_we_q ? cap_addr_q + CAP_ADDR_WIDTH'(1) : cap_addr_q;

        if (abort && (state_q != IDLE)) begin
            // Any byte still being packed is discarded.
            state_d = IDLE;
            tck_d   = 1'b0;
            gnd_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tck_d = 1'b0;
                    if (start) begin
                        bit_count_d = bit_count;
                        half_d      = half_eff;
                        bit_idx_d   = '0;
                        div_cnt_d   = '0;
                        cap_sr_d    = '0;
                        cap_addr_d  = '0;
                        if (bit_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            gnd_d   = 1'b1;
                            state_d = REQ;
                        end
                    end
                end

                REQ: begin
                    if (dr_s) begin
                        tms_d   = bus.vector_data[VEC_TMS_BIT];
                        tdi_d   = bus.vector_data[VEC_TDI_BIT];
                        gnd_d   = 1'b0;
                        state_d = ACK;
                    end
                end

                ACK: begin
                    if (!dr_s) begin
                        div_cnt_d = '0;
                        state_d   = LOW;
                    end
                end

                LOW: begin
                    if (half_last) begin
                        div_cnt_d = '0;
                        tck_d     = 1'b1;
                        state_d   = HIGH;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                    end
                end

                HIGH: begin
                    if (half_last) begin
                        div_cnt_d = '0;
                        tck_d     = 1'b0;
                        bit_idx_d = bit_idx_q + 32'd1;
                        // A full byte or the final bit flushes the packed byte;
                        // bits not yet filled stay 0 because the packer is cleared.
                        if ((bit_idx_q[2:0] == 3'd7) || last_bit) begin
                            cap_we_d      = 1'b1;
                            cap_wr_data_d = cap_byte;
                            cap_sr_d      = '0;
                        end else begin
                            cap_sr_d = cap_byte;
                        end
                        if (last_bit) begin
                            state_d = FLUSH;
                        end else begin
                            gnd_d   = 1'b1;
                            state_d = REQ;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                    end
                end

                FLUSH: begin
                    if (!cap_we_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_count_q   <= '0;
            bit_idx_q     <= '0;
            half_q        <= '0;
            div_cnt_q     <= '0;
            cap_sr_q      <= '0;
            cap_wr_data_q <= '0;
            cap_addr_q    <= '0;
            cap_we_q      <= 1'b0;
            tck_q         <= 1'b0;
            tms_q         <= 1'b1;
            tdi_q         <= 1'b0;
            gnd_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            bit_idx_q     <= bit_idx_d;
            half_q        <= half_d;
            div_cnt_q     <= div_cnt_d;
            cap_sr_q      <= cap_sr_d;
            cap_wr_data_q <= cap_wr_data_d;
            cap_addr_q    <= cap_addr_d;
            cap_we_q      <= cap_we_d;
            tck_q         <= tck_d;
            tms_q         <= tms_d;
            tdi_q         <= tdi_d;
            gnd_q         <= gnd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.get_next_data = gnd_q;
    assign bus.cap_addr      = cap_addr_q;
    assign bus.cap_wr_data   = cap_wr_data_q;
    assign bus.cap_we        = cap_we_q;
    assign tck               = tck_q;
    assign tms               = tms_q;
    assign tdi               = tdi_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_jtag_tck_shifter.sv
// -----------------------------------------------------------------------------
// tb_jtag_tck_shifter
// Directed bench: a table of complete runs (player vectors, TDO pattern and the
// hand-worked pin / capture results), plus hand-written sequences for a zero
// length run, abort mid-bit and reset mid-request.
// -----------------------------------------------------------------------------
module tb_jtag_tck_shifter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [31:0]   bit_count;
    logic [DW-1:0] tck_half_period;
    logic          tck, tms, tdi, tdo;
    logic          busy, done;

    jtag_tck_shifter_if #(.CAP_ADDR_WIDTH(AW)) bus ();

    jtag_tck_shifter #(.DIV_WIDTH(DW), .CAP_ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .bit_count       (bit_count),
        .tck_half_period (tck_half_period),
        .bus             (bus),
        .tck             (tck),
        .tms             (tms),
        .tdi             (tdi),
        .tdo             (tdo),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- player model (negedge) ----------------
    logic        p_clear;
    logic [31:0] p_vec;
    int unsigned p_dly, p_hold, p_cnt, p_vidx;
    int          p_st;

    initial begin
        forever begin
            @(negedge clk);
            if (p_clear) begin
                p_st             = 0;
                p_cnt            = 0;
                p_vidx           = 0;
                bus.data_ready   = 1'b0;
                bus.vector_data  = 2'b00;
            end else begin
                case (p_st)
                    0: if (bus.get_next_data) begin p_cnt = p_dly; p_st = 1; end
                    1: begin
                        if (p_cnt == 0) begin
                            bus.vector_data = 2'((p_vec >> (2 * p_vidx)) & 32'h3);
                            bus.data_ready  = 1'b1;
                            p_st            = 2;
                        end else p_cnt--;
                    end
                    2: if (!bus.get_next_data) begin p_cnt = p_hold; p_st = 3; end
                    3: begin
                        if (p_cnt == 0) begin
                            bus.data_ready = 1'b0;
                            p_vidx++;
                            p_st = 0;
                        end else p_cnt--;
                    end
                    default: p_st = 0;
                endcase
            end
        end
    end

    // ---------------- pin / capture monitor (posedge + 1) ----------------
    logic        mon_clear;
    logic [31:0] tdo_bits;
    int unsigned rise_cnt, fall_cnt, hl, done_cnt, gnd_rise;
    int unsigned viol_req, viol_tck, stable_err;
    logic [31:0] tms_log, tdi_log;
    int unsigned hl_log [32];
    logic        prev_tck, prev_gnd, prev_tms, prev_tdi;
    logic [AW-1:0] cap_a [$];
    logic [7:0]    cap_d [$];

    // TDO for bit k is presented from the moment bit k-1's TCK falls.
    assign tdo = tdo_bits[fall_cnt[4:0]];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_clear) begin
                rise_cnt = 0; fall_cnt = 0; hl = 0; done_cnt = 0; gnd_rise = 0;
                viol_req = 0; viol_tck = 0; stable_err = 0;
                tms_log = '0; tdi_log = '0;
                for (int i = 0; i < 32; i++) hl_log[i] = 0;
                cap_a.delete();
                cap_d.delete();
            end else begin
                if (tck && !prev_tck) begin
                    if (tms !== prev_tms || tdi !== prev_tdi) stable_err++;
                    tms_log[rise_cnt[4:0]] = tms;
                    tdi_log[rise_cnt[4:0]] = tdi;
                    rise_cnt++;
                    hl = 1;
                end else if (tck && prev_tck) begin
                    hl++;
                end else if (!tck && prev_tck) begin
                    hl_log[fall_cnt[4:0]] = hl;
                    fall_cnt++;
                end
                if (bus.cap_we) begin
                    cap_a.push_back(bus.cap_addr);
                    cap_d.push_back(bus.cap_wr_data);
                end
                if (done) done_cnt++;
                if (bus.get_next_data && !prev_gnd) begin
                    gnd_rise++;
                    if (bus.data_ready) viol_req++;
                end
                if ((bus.get_next_data || bus.data_ready) && tck) viol_tck++;
            end
            prev_tck = tck;
            prev_gnd = bus.get_next_data;
            prev_tms = tms;
            prev_tdi = tdi;
        end
    end

    // ---------------- run table ----------------
    typedef struct {
        int unsigned bc;
        int unsigned half;
        int unsigned dly;
        int unsigned hold;
        logic [31:0] pvec;
        logic [31:0] tdo;
        logic [31:0] etms;
        logic [31:0] etdi;
        int unsigned ncap;
        logic [7:0]  cap0;
        logic [7:0]  cap1;
        int unsigned ehl;
    } rec_t;

    rec_t tbl [5];

    task automatic clear_models();
        mon_clear = 1'b1;
        p_clear   = 1'b1;
        tick();
        mon_clear = 1'b0;
        p_clear   = 1'b0;
    endtask

    task automatic run_rec(input rec_t r, input string tag);
        p_dly    = r.dly;
        p_hold   = r.hold;
        p_vec    = r.pvec;
        tdo_bits = r.tdo;
        clear_models();
        bit_count       = r.bc;
        tck_half_period = DW'(r.half);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_start"}, busy, 1);
        for (int i = 0; i < 4000 && done_cnt == 0; i++) tick();
        chk({tag, ".done"}, done_cnt, 1);
        tick();
        tick();
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".done_once"}, done_cnt, 1);
        chk({tag, ".gnd_end"}, bus.get_next_data, 0);
        chk({tag, ".rises"}, rise_cnt, r.bc);
        for (int k = 0; k < int'(r.bc); k++)
            chk($sformatf("%s.high_len[%0d]", tag, k), hl_log[k], r.ehl);
        chk({tag, ".tms_seq"}, tms_log, r.etms);
        chk({tag, ".tdi_seq"}, tdi_log, r.etdi);
        chk({tag, ".pin_stable"}, stable_err, 0);
        chk({tag, ".req_while_ready"}, viol_req, 0);
        chk({tag, ".tck_in_wait"}, viol_tck, 0);
        chk({tag, ".vectors_used"}, p_vidx, r.bc);
        chk({tag, ".cap_count"}, cap_a.size(), r.ncap);
        if (cap_a.size() > 0) begin
            chk({tag, ".cap0_addr"}, cap_a[0], 0);
            chk({tag, ".cap0_data"}, cap_d[0], r.cap0);
        end
        if (r.ncap > 1 && cap_a.size() > 1) begin
            chk({tag, ".cap1_addr"}, cap_a[1], 1);
            chk({tag, ".cap1_data"}, cap_d[1], r.cap1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".tck"}, tck, 0);
        chk({tag, ".tms"}, tms, 1);
        chk({tag, ".tdi"}, tdi, 0);
        chk({tag, ".gnd"}, bus.get_next_data, 0);
        chk({tag, ".cap_we"}, bus.cap_we, 0);
        chk({tag, ".cap_addr"}, bus.cap_addr, 0);
        chk({tag, ".cap_wr_data"}, bus.cap_wr_data, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    initial begin
        //          bc half dly hold pvec          tdo          etms         etdi     ncap cap0   cap1  ehl
        tbl[0] = '{4,  2,   0,  0,   32'h0000_002D, 32'h0000_000B, 32'h0000_0003, 32'h0000_0006, 1, 8'h0B, 8'h00, 2};
        tbl[1] = '{16, 1,   1,  2,   32'hE4E4_1B1B, 32'h0000_3CA5, 32'h0000_AA55, 32'h0000_CC33, 2, 8'hA5, 8'h3C, 1};
        tbl[2] = '{3,  1,   20, 5,   32'h0000_0023, 32'h0000_0006, 32'h0000_0001, 32'h0000_0005, 1, 8'h06, 8'h00, 1};
        tbl[3] = '{1,  0,   0,  0,   32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1, 8'h01, 8'h00, 1};
        tbl[4] = '{9,  3,   2,  1,   32'h0001_5555, 32'h0000_015A, 32'h0000_01FF, 32'h0000_0000, 2, 8'h5A, 8'h01, 3};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bit_count = '0; tck_half_period = '0;
        tdo_bits = '0; p_vec = '0; p_dly = 0; p_hold = 0;
        mon_clear = 1'b1; p_clear = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_rec(tbl[i], $sformatf("run%0d", i));

        // Zero-length run: done the cycle after start, no request ever.
        clear_models();
        bit_count = 0; tck_half_period = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero.done", done, 1);
        chk("zero.busy", busy, 0);
        tick();
        chk("zero.done_clear", done, 0);
        repeat (5) tick();
        chk("zero.no_request", gnd_rise, 0);
        chk("zero.no_tck", rise_cnt, 0);

        // Abort in the HIGH phase of bit 5 of a 12-bit run.
        p_dly = 0; p_hold = 0; p_vec = 32'h00AA_AAAA; tdo_bits = 32'hFFFF_FFFF;
        clear_models();
        bit_count = 12; tck_half_period = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2000 && rise_cnt < 6; i++) tick();
        chk("abort.in_high", tck, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.tck", tck, 0);
        chk("abort.gnd", bus.get_next_data, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 1);
        repeat (10) tick();
        chk("abort.no_cap", cap_a.size(), 0);
        chk("abort.done_once", done_cnt, 1);
        chk("abort.rises", rise_cnt, 6);
        chk("abort.idle_gnd", bus.get_next_data, 0);
        run_rec(tbl[0], "post_abort");

        // Asynchronous reset while waiting in REQ.
        p_dly = 30; p_hold = 0; p_vec = 32'h0000_FFFF; tdo_bits = 32'h0;
        clear_models();
        bit_count = 8; tck_half_period = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("rst_mid.in_req", bus.get_next_data, 1);
        rst_n   = 1'b0;
        p_clear = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        tick();
        p_clear = 1'b0;
        rst_n   = 1'b1;
        tick();
        run_rec(tbl[0], "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
